multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Parametrised successor to the multi-cycle control unit. It sequences RV32 R/I/U/S/B/J instructions through fetch, decode, execute, memory and write-back states. It adds three things: a ready/request handshake with instruction/data memory, a memory-timeout halt, and an instruction-retired counter. The block sits between the IR/decoder fields and the datapath enables (PC, IR, register file, ALU, memory).

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter
- MEM_TO, 16, max cycles waiting for `mem_ready` before halting; 0 disables timeout

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- zf  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- alu_op  out  4  ALU operation
- rs2_imm_s  out  1  ALU B operand: 0 = rs2, 1 = imm
- w_data_s  out  2  register write data: 00 = ALU, 01 = mem, 10 = imm (LUI), 11 = PC+4
- pc_src  out  2  next PC: 00 = PC+4, 01 = PC+imm, 10 = ALU (JALR)
- reg_write, ir_write, pc_write, mem_write, mem_req  out  1 each  datapath enables
- instret  out  CNT_W  retired-instruction count
- halted  out  1  sticky; set on timeout or illegal trap
- illegal  out  1  sticky illegal-opcode flag (see Configuration)

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, LUI, HALT.
- IDLE → FETCH unconditionally.
- FETCH:
  - Asserts `mem_req`.
  - On `mem_ready`, asserts `ir_write` and `pc_write` (pc_src = 00) and moves to DECODE.
  - Otherwise stays in FETCH.
- DECODE dispatches on opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 / 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 / 1100111 → JUMP
  - 0110111 → LUI
  - anything else → see Configuration
- EXEC_R: `alu_op` = {funct7[5], funct3}, rs2_imm_s = 0; → WB_ALU.
- EXEC_I: `alu_op` = {funct3==101 ? funct7[5] : 0, funct3}, rs2_imm_s = 1; → WB_ALU.
- WB_ALU: reg_write = 1, w_data_s = 00; → FETCH.
- MEM_ADDR: `alu_op` = 0000 (ADD), rs2_imm_s = 1. Load → MEM_RD; store → MEM_WR.
- MEM_RD: mem_req = 1; wait for `mem_ready`, then → WB_MEM.
- WB_MEM: reg_write = 1, w_data_s = 01; → FETCH.
- MEM_WR: mem_req = 1, mem_write = 1 for every cycle spent in the state; on `mem_ready` → FETCH.
- BRANCH (BEQ/BNE):
  - `alu_op` = 1000 (SUB), rs2_imm_s = 0.
  - pc_write = zf ^ funct3[0], pc_src = 01.
  - → FETCH.
- JUMP:
  - reg_write = 1, w_data_s = 11, pc_write = 1.
  - pc_src = 01 for JAL, 10 for JALR; for JALR, alu_op = ADD and rs2_imm_s = 1.
  - → FETCH.
- LUI: reg_write = 1, w_data_s = 10; → FETCH.
- `instret` increments by 1 on every transition into FETCH from a non-IDLE, non-HALT state. It wraps modulo 2^CNT_W.
- Timeout:
  - A wait counter runs in FETCH, MEM_RD and MEM_WR. It clears on state entry and on `mem_ready`.
  - When MEM_TO ≠ 0 and the counter reaches MEM_TO with `mem_ready` low, the FSM goes to HALT and `halted` is set.
- HALT: all enables 0; the FSM stays in HALT until `rst`.

## Timing
- On reset, every output is 0 and the state is IDLE. `instret`, `halted`, `illegal` and the wait counter all clear.
- Asserting `rst` mid-instruction aborts immediately and asynchronously. No enable may glitch high after that.
- The state register and flags are registered.
- Enables are decoded from the state. These are the only input-dependent terms:
  - FETCH `ir_write`/`pc_write` = `mem_ready`.
  - MEM_RD/MEM_WR exit on `mem_ready`.
  - BRANCH `pc_write` depends on `zf`.
- Cycle counts with zero-wait memory (`mem_ready` high in the first request cycle):
  - R/I: 4
  - load: 5
  - store: 4
  - branch, JAL/JALR, LUI: 3
- Each extra wait cycle adds 1.
- `mem_ready` is ignored outside FETCH/MEM_RD/MEM_WR.
- A timeout and `mem_ready` arriving in the same cycle: `mem_ready` wins.

## Configuration
- `MULTICYCLE_CTRL_ILLEGAL_TRAP_EN` defined: an unknown opcode in DECODE sets `illegal` and `halted` and the FSM goes to HALT.
- Undefined: an unknown opcode is treated as a NOP. DECODE → FETCH, `instret` increments, and `illegal` is tied to 0.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - state enum
  - opcode constants
  - ALU_OP encodings (ADD = 0000, SUB = 1000)
  - w_data_s and pc_src encodings
- One natural sub-module, `mc_wait_timer`: the MEM_TO wait counter with clear and timeout outputs.
- FSM and output decode live in the top module.

## Test plan
- Reset with `mem_ready` = 1, R-type ADD (opcode 0110011, funct3 000, funct7 0) → FETCH/DECODE/EXEC_R/WB_ALU. `alu_op` = 0000, reg_write high in cycle 4, `instret` = 1.
- LW (0000011/010), `mem_ready` low 2 cycles in MEM_RD → load takes 7 cycles. `w_data_s` = 01 in WB_MEM; `mem_write` never high.
- SW (0100011/010) → `mem_write` = `mem_req` = 1 throughout MEM_WR, then FETCH. `reg_write` stays 0.
- BEQ with zf = 1, then BNE with zf = 1 → pc_write = 1 with pc_src = 01 for BEQ; pc_write = 0 for BNE.
- MEM_TO = 4, `mem_ready` held 0 in FETCH → HALT after 4 cycles, `halted` = 1. `rst` pulse clears it and returns to IDLE.
- Opcode 1111111 → with the macro: `illegal` = `halted` = 1. Without it: returns to FETCH and `instret` increments.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM state encoding,
// RV32 opcode constants, ALU operation codes and datapath mux encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_WB_ALU   = 4'd8,
        ST_WB_MEM   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_LUI      = 4'd12,
        ST_HALT     = 4'd13
    } state_t;

    // RV32 major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    // Register write-data select
    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_IMM = 2'b10;
    localparam logic [1:0] WD_PC4 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    // True for every opcode the controller knows how to sequence
    function automatic logic is_known_op(input logic [6:0] op);
        logic known;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: known = 1'b1;
            default:                            known = 1'b0;
        endcase
        return known;
    endfunction

    // States that wait on the memory handshake (and therefore on the timer)
    function automatic logic is_wait_state(input state_t s);
        logic w;
        case (s)
            ST_FETCH, ST_MEM_RD, ST_MEM_WR: w = 1'b1;
            default:                        w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait timer. Counts consecutive cycles spent in a memory-wait state
// without mem_ready and flags a timeout on the MEM_TO-th such cycle.
// MEM_TO = 0 removes the counter entirely and never times out.
module mc_wait_timer #(
    parameter int MEM_TO = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic clear,
    input  logic mem_ready,
    output logic timeout
);

    generate
        if (MEM_TO == 0) begin : g_off
            logic unused_s;
            assign unused_s = ^{clk, rst, active, clear, mem_ready};
            assign timeout  = 1'b0;
        end else begin : g_on
            localparam int CW = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;
            localparam logic [CW-1:0] LAST = CW'(MEM_TO - 1);

            logic [CW-1:0] count_r;

            // Count stalled cycles; restart on state change, on handshake or outside wait states
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count_r <= {CW{1'b0}};
                end else if (clear || !active || mem_ready) begin
                    count_r <= {CW{1'b0}};
                end else if (count_r != LAST) begin
                    count_r <= count_r + CW'(1);
                end else begin
                    count_r <= count_r;
                end
            end

            // mem_ready in the final cycle wins over the timeout
            assign timeout = active && !mem_ready && (count_r == LAST);
        end
    endgenerate

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control unit: sequences fetch/decode/execute/memory/
// write-back with a memory ready/request handshake, a memory-timeout halt
// and a retired-instruction counter.
// Build option: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN makes unknown opcodes trap
// to HALT with the illegal flag set; otherwise they retire as NOPs.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int MEM_TO = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             zf,
    input  logic             mem_ready,
    output logic [3:0]       alu_op,
    output logic             rs2_imm_s,
    output logic [1:0]       w_data_s,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             mem_write,
    output logic             mem_req,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic             illegal
);

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] instret_r;
    logic             halted_r;
    logic             illegal_r;
    logic             timeout_s;
    logic             wait_active_s;
    logic             state_change_s;
    logic             unused_s;

    // Only funct7[5] selects between ALU op variants
    assign unused_s = ^{funct7[6], funct7[4:0]};

    assign wait_active_s  = is_wait_state(state_r);
    assign state_change_s = (state_next_s != state_r);

    mc_wait_timer #(
        .MEM_TO (MEM_TO)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .active    (wait_active_s),
        .clear     (state_change_s),
        .mem_ready (mem_ready),
        .timeout   (timeout_s)
    );

    // Next-state selection
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: state_next_s = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    state_next_s = ST_DECODE;
                end else if (timeout_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_R:               state_next_s = ST_EXEC_R;
                    OP_I:               state_next_s = ST_EXEC_I;
                    OP_LOAD, OP_STORE:  state_next_s = ST_MEM_ADDR;
                    OP_BRANCH:          state_next_s = ST_BRANCH;
                    OP_JAL, OP_JALR:    state_next_s = ST_JUMP;
                    OP_LUI:             state_next_s = ST_LUI;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    default:            state_next_s = ST_HALT;
`else
                    default:            state_next_s = ST_FETCH;
`endif
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: state_next_s = ST_WB_ALU;
            ST_MEM_ADDR: begin
                if (opcode == OP_LOAD) begin
                    state_next_s = ST_MEM_RD;
                end else begin
                    state_next_s = ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                if (mem_ready) begin
                    state_next_s = ST_WB_MEM;
                end else if (timeout_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_MEM_RD;
                end
            end
            ST_MEM_WR: begin
                if (mem_ready) begin
                    state_next_s = ST_FETCH;
                end else if (timeout_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_MEM_WR;
                end
            end
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP, ST_LUI: state_next_s = ST_FETCH;
            ST_HALT: state_next_s = ST_HALT;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register, retired counter and sticky status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            instret_r <= {CNT_W{1'b0}};
            halted_r  <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            // An instruction retires whenever a real instruction hands back to FETCH
            if ((state_next_s == ST_FETCH) && (state_r != ST_IDLE) &&
                (state_r != ST_FETCH) && (state_r != ST_HALT)) begin
                instret_r <= instret_r + CNT_W'(1);
            end else begin
                instret_r <= instret_r;
            end
            if (state_next_s == ST_HALT) begin
                halted_r <= 1'b1;
            end else begin
                halted_r <= halted_r;
            end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            if ((state_r == ST_DECODE) && !is_known_op(opcode)) begin
                illegal_r <= 1'b1;
            end else begin
                illegal_r <= illegal_r;
            end
`else
            illegal_r <= 1'b0;
`endif
        end
    end

    // Datapath enables decoded from the registered state
    always_comb begin
        alu_op    = ALU_ADD;
        rs2_imm_s = 1'b0;
        w_data_s  = WD_ALU;
        pc_src    = PC_PLUS4;
        reg_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        mem_write = 1'b0;
        mem_req   = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
                pc_src   = PC_PLUS4;
            end
            ST_EXEC_R: begin
                alu_op    = {funct7[5], funct3};
                rs2_imm_s = 1'b0;
            end
            ST_EXEC_I: begin
                alu_op    = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
                rs2_imm_s = 1'b1;
            end
            ST_MEM_ADDR: begin
                alu_op    = ALU_ADD;
                rs2_imm_s = 1'b1;
            end
            ST_MEM_RD: begin
                mem_req = 1'b1;
            end
            ST_MEM_WR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
            end
            ST_WB_ALU: begin
                reg_write = 1'b1;
                w_data_s  = WD_ALU;
            end
            ST_WB_MEM: begin
                reg_write = 1'b1;
                w_data_s  = WD_MEM;
            end
            ST_BRANCH: begin
                alu_op    = ALU_SUB;
                rs2_imm_s = 1'b0;
                pc_write  = zf ^ funct3[0];
                pc_src    = PC_IMM;
            end
            ST_JUMP: begin
                reg_write = 1'b1;
                w_data_s  = WD_PC4;
                pc_write  = 1'b1;
                if (opcode == OP_JALR) begin
                    pc_src    = PC_ALU;
                    alu_op    = ALU_ADD;
                    rs2_imm_s = 1'b1;
                end else begin
                    pc_src    = PC_IMM;
                end
            end
            ST_LUI: begin
                reg_write = 1'b1;
                w_data_s  = WD_IMM;
            end
            default: begin
                alu_op = ALU_ADD;
            end
        endcase
    end

    assign instret = instret_r;
    assign halted  = halted_r;
    assign illegal = illegal_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl (MEM_TO = 4). Each cycle the
// expected output vector is queued as stimulus is applied and popped for
// comparison mid-cycle once the DUT outputs have settled.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        zf;
    logic        mem_ready;
    logic [3:0]  alu_op;
    logic        rs2_imm_s;
    logic [1:0]  w_data_s;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic        ir_write;
    logic        pc_write;
    logic        mem_write;
    logic        mem_req;
    logic [31:0] instret;
    logic        halted;
    logic        illegal;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic        rs2_imm_s;
        logic [1:0]  w_data_s;
        logic [1:0]  pc_src;
        logic [4:0]  en;       // {reg_write, ir_write, pc_write, mem_write, mem_req}
        logic [31:0] instret;
        logic        halted;
        logic        illegal;
    } out_t;

    out_t        sb_q[$];
    out_t        obs_s;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_instret = 32'd0;
    logic        exp_halted  = 1'b0;
    logic        exp_illegal = 1'b0;

    multicycle_ctrl #(
        .CNT_W  (32),
        .MEM_TO (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .zf        (zf),
        .mem_ready (mem_ready),
        .alu_op    (alu_op),
        .rs2_imm_s (rs2_imm_s),
        .w_data_s  (w_data_s),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .mem_write (mem_write),
        .mem_req   (mem_req),
        .instret   (instret),
        .halted    (halted),
        .illegal   (illegal)
    );

    assign obs_s = {alu_op, rs2_imm_s, w_data_s, pc_src,
                    reg_write, ir_write, pc_write, mem_write, mem_req,
                    instret, halted, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input logic [3:0] a, input logic b,
                                input logic [1:0] wd, input logic [1:0] ps,
                                input logic [4:0] en);
        return {a, b, wd, ps, en, exp_instret, exp_halted, exp_illegal};
    endfunction

    // Queue expectation, compare mid-cycle, then advance to just after the next edge
    task automatic cyc(input string tag, input out_t e);
        out_t exp_v;
        out_t got_v;
        sb_q.push_back(e);
        #2;
        got_v = obs_s;
        exp_v = sb_q.pop_front();
        tests++;
        assert (got_v === exp_v) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, got_v, exp_v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string tag);
        mem_ready = 1'b1;
        cyc({tag, "_fetch"},  mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b01101));
        cyc({tag, "_decode"}, mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00000));
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b1; zf = 1'b0;
        opcode = 7'b0000000; funct3 = 3'b000; funct7 = 7'b0000000;
        #1;
        cyc("reset", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00000));
        rst = 1'b0;
        cyc("idle", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00000));

        // R-type ADD
        opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000;
        fetch_decode("add");
        cyc("add_exec", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00000));
        cyc("add_wb",   mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b10000));
        exp_instret++;

        // I-type SRAI: funct7[5] reaches alu_op
        opcode = 7'b0010011; funct3 = 3'b101; funct7 = 7'b0100000;
        fetch_decode("srai");
        cyc("srai_exec", mk(4'b1101, 1'b1, 2'b00, 2'b00, 5'b00000));
        cyc("srai_wb",   mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b10000));
        exp_instret++;

        // I-type ADDI with imm bit 30 set: funct7[5] must not leak
        opcode = 7'b0010011; funct3 = 3'b000; funct7 = 7'b0100000;
        fetch_decode("addi");
        cyc("addi_exec", mk(4'b0000, 1'b1, 2'b00, 2'b00, 5'b00000));
        cyc("addi_wb",   mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b10000));
        exp_instret++;

        // LW with two wait cycles in MEM_RD: 7 cycles total
        opcode = 7'b0000011; funct3 = 3'b010; funct7 = 7'b0000000;
        fetch_decode("lw");
        cyc("lw_addr", mk(4'b0000, 1'b1, 2'b00, 2'b00, 5'b00000));
        mem_ready = 1'b0;
        cyc("lw_rd_w1", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00001));
        cyc("lw_rd_w2", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00001));
        mem_ready = 1'b1;
        cyc("lw_rd_ok", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00001));
        cyc("lw_wb",    mk(4'b0000, 1'b0, 2'b01, 2'b00, 5'b10000));
        exp_instret++;

        // SW: ready arrives in the cycle the timer would expire, ready wins
        opcode = 7'b0100011; funct3 = 3'b010;
        fetch_decode("sw");
        cyc("sw_addr", mk(4'b0000, 1'b1, 2'b00, 2'b00, 5'b00000));
        mem_ready = 1'b0;
        cyc("sw_wr_w1", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00011));
        cyc("sw_wr_w2", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00011));
        cyc("sw_wr_w3", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00011));
        mem_ready = 1'b1;
        cyc("sw_wr_ok", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00011));
        exp_instret++;

        // BEQ taken with zf = 1
        opcode = 7'b1100011; funct3 = 3'b000; zf = 1'b1;
        fetch_decode("beq");
        cyc("beq_br", mk(4'b1000, 1'b0, 2'b00, 2'b01, 5'b00100));
        exp_instret++;

        // BNE not taken with zf = 1
        funct3 = 3'b001;
        fetch_decode("bne");
        cyc("bne_br", mk(4'b1000, 1'b0, 2'b00, 2'b01, 5'b00000));
        exp_instret++;
        zf = 1'b0;

        // JAL
        opcode = 7'b1101111; funct3 = 3'b000;
        fetch_decode("jal");
        cyc("jal_j", mk(4'b0000, 1'b0, 2'b11, 2'b01, 5'b10100));
        exp_instret++;

        // JALR
        opcode = 7'b1100111;
        fetch_decode("jalr");
        cyc("jalr_j", mk(4'b0000, 1'b1, 2'b11, 2'b10, 5'b10100));
        exp_instret++;

        // LUI
        opcode = 7'b0110111;
        fetch_decode("lui");
        cyc("lui_wb", mk(4'b0000, 1'b0, 2'b10, 2'b00, 5'b10000));
        exp_instret++;

        // Fetch timeout: four stalled cycles, then HALT
        mem_ready = 1'b0;
        cyc("to_f1", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00001));
        cyc("to_f2", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00001));
        cyc("to_f3", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00001));
        cyc("to_f4", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00001));
        exp_halted = 1'b1;
        cyc("halt1", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00000));
        mem_ready = 1'b1;
        cyc("halt2", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00000));

        // Asynchronous reset pulse clears everything
        rst = 1'b1;
        exp_halted = 1'b0; exp_instret = 32'd0; exp_illegal = 1'b0;
        cyc("rst_pulse", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00000));
        rst = 1'b0;
        cyc("idle2", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00000));

        // Unknown opcode
        opcode = 7'b1111111;
        fetch_decode("unk");
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        exp_halted = 1'b1; exp_illegal = 1'b1;
        cyc("unk_halt", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b00000));
`else
        exp_instret++;
        cyc("unk_nop_fetch", mk(4'b0000, 1'b0, 2'b00, 2'b00, 5'b01101));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
